// File: rtl/uart_rx_top.sv
// 8N1 UART receiver feeding a circular byte buffer.
// The core drains bytes through a one-cycle-latency read port.
module uart_rx_top #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH_LOG2  = 10
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  input  logic       rd_en,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       empty,
  output logic       overrun,
  output logic       ferr,
  input  logic       clr_err
);

  localparam int HALF = CLK_PER_BIT / 2;
  localparam int CW   = $clog2(CLK_PER_BIT);
  localparam int D    = DEPTH_LOG2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          rx_m, rx_s;
  logic          push, set_ferr;

  logic [7:0]    mem [2**D];
  logic [D:0]    wp, rp;
  logic          full;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rxd;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    sh_n     = sh;
    push     = 1'b0;
    set_ferr = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CW'(CLK_PER_BIT - 1)) begin
          cnt_n     = '0;
          sh_n[idx] = rx_s;
          idx_n     = idx + 1'b1;
          if (idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CW'(CLK_PER_BIT - 1)) begin
          cnt_n = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            set_ferr = 1'b1;
            state_n  = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign empty = (wp == rp);
  assign full  = (wp[D] != rp[D]) &&
                 (wp[D-1:0] == rp[D-1:0]);

  // RAM is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[D-1:0]] <= sh;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp      <= '0;
      rp      <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
      overrun <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (rd_en && !empty) begin
        rdata  <= mem[rp[D-1:0]];
        rp     <= rp + 1'b1;
        rvalid <= 1'b1;
      end else begin
        rvalid <= 1'b0;
      end
      if (clr_err) begin
        overrun <= 1'b0;
        ferr    <= 1'b0;
      end else begin
        if (push && full) overrun <= 1'b1;
        if (set_ferr)     ferr    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top with CLK_PER_BIT=16, DEPTH_LOG2=2.
// Frames are driven bit by bit; results checked #1 after posedge.
module tb_uart_rx_top;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rdata;
  logic       rvalid, empty, overrun, ferr;

  int checks = 0;
  int errors = 0;

  uart_rx_top #(.CLK_PER_BIT(CPB), .DEPTH_LOG2(2)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rxd     (rxd),
    .rd_en   (rd_en),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .empty   (empty),
    .overrun (overrun),
    .ferr    (ferr),
    .clr_err (clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_stored;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[5];

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bit_out(logic b);
    rxd = b;
    tick(CPB);
  endtask

  task automatic send(logic [7:0] b, logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
  endtask

  task automatic read_chk(string nm, logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({nm, "_rvalid"}, rvalid, 1);
    chk({nm, "_rdata"}, rdata, exp);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0};

    tick(3);
    rstn = 1'b1;
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_overrun", overrun, 0);
    chk("rst_ferr", ferr, 0);
    tick(5);

    // read while empty is ignored
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("empty_rd_rvalid", rvalid, 0);

    foreach (vecs[i]) begin
      send(vecs[i].data, vecs[i].stop);
      rxd = 1'b1;
      tick(4);
      chk($sformatf("v%0d_empty", i), empty, !vecs[i].exp_stored);
      chk($sformatf("v%0d_ferr", i), ferr, vecs[i].exp_ferr);
      if (vecs[i].exp_stored) begin
        read_chk($sformatf("v%0d", i), vecs[i].data);
        chk($sformatf("v%0d_empty_after", i), empty, 1);
      end
      pulse_clr();
      chk($sformatf("v%0d_ferr_clr", i), ferr, 0);
    end

    // burst of three, read back-to-back, fourth read empty
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'hA5, 1'b1);
    rd_en = 1'b1;
    tick();
    chk("burst0", rdata, 8'h00);
    chk("burst0_v", rvalid, 1);
    tick();
    chk("burst1", rdata, 8'hFF);
    tick();
    chk("burst2", rdata, 8'hA5);
    tick();
    rd_en = 1'b0;
    chk("burst3_rvalid", rvalid, 0);
    chk("burst3_rdata_hold", rdata, 8'hA5);
    chk("burst_empty", empty, 1);

    // glitch shorter than half a bit
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(40);
    chk("glitch_empty", empty, 1);
    chk("glitch_ferr", ferr, 0);
    send(8'h5A, 1'b1);
    tick(2);
    read_chk("post_glitch", 8'h5A);

    // framing error followed by a long break
    send(8'h3C, 1'b0);
    rxd = 1'b0;
    tick(40);
    chk("brk_ferr", ferr, 1);
    chk("brk_empty", empty, 1);
    rxd = 1'b1;
    tick(20);
    chk("brk_no_frame", empty, 1);
    send(8'h12, 1'b1);
    tick(2);
    read_chk("brk_next", 8'h12);
    chk("brk_ferr_sticky", ferr, 1);
    pulse_clr();
    chk("brk_ferr_clr", ferr, 0);

    // overrun: 5 bytes into a 4-deep buffer
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    tick(2);
    chk("ovr_flag", overrun, 1);
    for (int i = 1; i <= 4; i++)
      read_chk($sformatf("ovr_rd%0d", i), 8'(i));
    chk("ovr_empty", empty, 1);
    pulse_clr();
    chk("ovr_clr", overrun, 0);

    // six more across the pointer wrap
    for (int i = 0; i < 6; i++) begin
      send(8'h10 + 8'(i), 1'b1);
      tick(2);
      read_chk($sformatf("wrap%0d", i), 8'h10 + 8'(i));
    end
    chk("wrap_empty", empty, 1);
    chk("wrap_overrun", overrun, 0);

    // reset during data bit 3, with a byte left in the buffer
    send(8'h99, 1'b1);
    tick(2);
    chk("pre_rst_empty", empty, 0);
    bit_out(1'b0);
    for (int i = 0; i < 3; i++) bit_out(1'b1);
    rxd = 1'b0;
    tick(8);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    rxd = 1'b1;
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_ferr", ferr, 0);
    chk("mid_rst_overrun", overrun, 0);
    tick(40);
    chk("mid_rst_idle", empty, 1);
    send(8'h81, 1'b1);
    tick(2);
    read_chk("post_rst", 8'h81);
    chk("post_rst_empty", empty, 1);
    chk("post_rst_ferr", ferr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
